vx_warp_commit_tracker: RTL

Per-warp in-flight instruction tracker that sits directly downstream of the commit stage's scheduler feedback bundle (`committed`, `committed_wid`, `true_eop` per issue slot) and upstream of the warp scheduler. It counts instructions issued but not yet fully committed for every warp. It exposes a per-warp pending mask and a per-warp issue-credit signal. It also runs a single-outstanding drain (fence) handshake that completes once a chosen warp has no instructions in flight.

---
 rtl/vx_warp_commit_tracker_pkg.sv | 14 +
 rtl/vx_warp_commit_tracker_popcount.sv | 26 ++
 rtl/vx_warp_commit_tracker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vx_warp_commit_tracker_pkg.sv
// Shared types and default sizing for the warp commit tracker.
package vx_warp_commit_tracker_pkg;

  localparam int DEF_NUM_WARPS   = 8;
  localparam int DEF_ISSUE_WIDTH = 2;
  localparam int DEF_MAX_PENDING = 15;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_WAIT,
    DRAIN_DONE
  } drain_state_e;

endpackage

// File: rtl/vx_warp_commit_tracker_popcount.sv
// Per-warp decode of the commit slots: counts end-of-packet retires for every warp.
module vx_warp_commit_tracker_popcount #(
  parameter int NUM_WARPS   = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int NW_WIDTH    = 3,
  parameter int DEC_WIDTH   = 2
) (
  input  logic [ISSUE_WIDTH-1:0]           committed,
  input  logic [ISSUE_WIDTH*NW_WIDTH-1:0]  committed_wid,
  input  logic [ISSUE_WIDTH-1:0]           true_eop,
  output logic [NUM_WARPS*DEC_WIDTH-1:0]   dec_flat
);

  always_comb begin
    dec_flat = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (committed[s] && true_eop[s] &&
            committed_wid[s*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)) begin
          dec_flat[w*DEC_WIDTH +: DEC_WIDTH] = dec_flat[w*DEC_WIDTH +: DEC_WIDTH] + DEC_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vx_warp_commit_tracker.sv
// Per-warp in-flight instruction counters with issue credit, pending mask and
// a single-outstanding drain (fence) handshake.
module vx_warp_commit_tracker
  import vx_warp_commit_tracker_pkg::*;
#(
  parameter int NUM_WARPS   = DEF_NUM_WARPS,
  parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CTR_WIDTH   = $clog2(MAX_PENDING + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic [NW_WIDTH-1:0]             issue_wid,
  input  logic [ISSUE_WIDTH-1:0]          committed,
  input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] committed_wid,
  input  logic [ISSUE_WIDTH-1:0]          true_eop,
  output logic [NUM_WARPS-1:0]            issue_ready,
  output logic [NUM_WARPS-1:0]            pending_mask,
  input  logic                            drain_req_valid,
  input  logic [NW_WIDTH-1:0]             drain_req_wid,
  output logic                            drain_req_ready,
  output logic                            drain_done,
  output logic [NW_WIDTH-1:0]             drain_done_wid,
  output logic                            underflow_err
);

  localparam int DEC_WIDTH = $clog2(ISSUE_WIDTH + 1);
  localparam int SUM_WIDTH = ((CTR_WIDTH > DEC_WIDTH) ? CTR_WIDTH : DEC_WIDTH) + 1;

  logic [NUM_WARPS*DEC_WIDTH-1:0]      dec_flat;
  logic [NUM_WARPS-1:0][CTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                                underflow_q, underflow_d;
  drain_state_e                        state_q, state_d;
  logic [NW_WIDTH-1:0]                 dwid_q, dwid_d;

  vx_warp_commit_tracker_popcount #(
    .NUM_WARPS   (NUM_WARPS),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .NW_WIDTH    (NW_WIDTH),
    .DEC_WIDTH   (DEC_WIDTH)
  ) u_popcount (
    .committed     (committed),
    .committed_wid (committed_wid),
    .true_eop      (true_eop),
    .dec_flat      (dec_flat)
  );

  // Issue past the limit is a scheduler bug; saturate silently rather than wrap.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      logic [SUM_WIDTH-1:0] sum;
      logic [SUM_WIDTH-1:0] dec_w;
      sum   = SUM_WIDTH'(cnt_q[w]) + SUM_WIDTH'(issue_valid && (issue_wid == NW_WIDTH'(w)));
      dec_w = SUM_WIDTH'(dec_flat[w*DEC_WIDTH +: DEC_WIDTH]);
      if (dec_w > sum) begin
        cnt_d[w]    = '0;
        underflow_d = 1'b1;
      end else if ((sum - dec_w) > SUM_WIDTH'(MAX_PENDING)) begin
        cnt_d[w] = CTR_WIDTH'(MAX_PENDING);
      end else begin
        cnt_d[w] = CTR_WIDTH'(sum - dec_w);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      issue_ready[w]  = (cnt_q[w] != CTR_WIDTH'(MAX_PENDING));
      pending_mask[w] = (cnt_q[w] != '0);
    end
  end

  // WAIT looks at the next-state count so a final retire completes one cycle later.
  always_comb begin
    state_d         = state_q;
    dwid_d          = dwid_q;
    drain_req_ready = 1'b0;
    drain_done      = 1'b0;
    drain_done_wid  = '0;
    case (state_q)
      DRAIN_IDLE: begin
        drain_req_ready = 1'b1;
        if (drain_req_valid) begin
          dwid_d  = drain_req_wid;
          state_d = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (cnt_d[dwid_q] == '0) state_d = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        drain_done     = 1'b1;
        drain_done_wid = dwid_q;
        state_d        = DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  assign underflow_err = underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      underflow_q <= 1'b0;
      state_q     <= DRAIN_IDLE;
      dwid_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
      dwid_q      <= dwid_d;
    end
  end

endmodule
